dtack_wait_state_controller: RTL
================================

Name: dtack_wait_state_controller

Overview:
Clocked Dtack sequencer for the 68k bus. It inserts programmable wait states per slow-device slot and optionally waits for a device-generated Dtack. A watchdog raises BusError_L when no Dtack arrives in time. It sits between the address decoder/device controllers and the CPU DTACK/BERR pins, and replaces fixed combinational Dtack for Flash, DRAM, CanBus and similar devices.

Parameters:
NUM_SLOTS, 4, number of slow-device slots (select/dtack pairs)
WAIT_WIDTH, 5, width of per-slot wait-state count
DEFAULT_WAITS, 2, reset value of every slot's wait count
TIMEOUT_CYCLES, 255, clocks after AS_L low before bus error (range 8..1023)

Ports:
Clock  in  1  system clock; all logic on rising edge
Reset_H  in  1  synchronous, active-high reset
AS_L  in  1  CPU address strobe, already synchronised to Clock
Select_H  in  NUM_SLOTS  per-slot select from address decoder
DevDtack_L  in  NUM_SLOTS  per-slot device-ready Dtack (active low)
CfgWrite_H  in  1  one-cycle strobe; writes slot configuration
CfgSlot  in  $clog2(NUM_SLOTS)  slot index for config write
CfgWaits  in  WAIT_WIDTH  wait-state count for that slot
CfgExtDtack_H  in  1  1 = after waits, also wait for DevDtack_L
ClearTimeout_H  in  1  clears TimeoutSticky_H
DtackOut_L  out  1  registered Dtack to CPU
BusError_L  out  1  registered BERR to CPU
TimeoutSticky_H  out  1  set on any timeout, held until cleared

Behaviour:
- Decided: one clock, Clock; reset synchronous active-high on Reset_H.
- Reset: state IDLE, DtackOut_L=1, BusError_L=1, TimeoutSticky_H=0, all slot waits=DEFAULT_WAITS, all ExtDtack=0, counters=0. Reset asserted mid-cycle aborts that cycle. Dtack is not issued again until AS_L is seen high and then low.
- All outputs are registered. Every output change appears on the edge after the input sample that causes it.
- FSM states: IDLE, COUNT, WAIT_EXT, ASSERT, BERR, WAIT_AS_HIGH.
- IDLE, AS_L=0, no Select_H set: go to ASSERT. DtackOut_L=0 one clock after AS_L is first sampled low (the default fast path).
- IDLE, AS_L=0, one or more Select_H set:
  - Latch the lowest set index k and slot k's config (Waits, ExtDtack).
  - Load the wait counter with Waits[k].
  - If Waits=0 and ExtDtack=0, go to ASSERT.
  - If Waits=0 and ExtDtack=1, go to WAIT_EXT.
  - Otherwise go to COUNT.
- COUNT: decrement each clock. On the clock the counter reaches 0, go to ASSERT if ExtDtack=0, else WAIT_EXT. Waits=N gives DtackOut_L low N+1 clocks after AS_L sampled low.
- WAIT_EXT: when DevDtack_L[k]=0 is sampled, go to ASSERT.
- ASSERT: DtackOut_L=0; hold until AS_L sampled 1, then DtackOut_L=1 and go to IDLE.
- Watchdog:
  - Counts clocks from AS_L first sampled low while in COUNT or WAIT_EXT.
  - Reaching TIMEOUT_CYCLES before ASSERT moves to BERR: BusError_L=0, DtackOut_L stays 1, TimeoutSticky_H set.
  - BERR holds until AS_L sampled 1; then BusError_L=1 and go to IDLE.
- Abort: AS_L sampled 1 in COUNT or WAIT_EXT returns to IDLE with no Dtack and no BERR.
- Back-to-back cycles: AS_L must be sampled high at least one clock between cycles. Dtack never carries into the next cycle.
- Select_H changes after latch are ignored for the current cycle.
- Config write during a cycle updates the table immediately but takes effect from the next cycle. CfgSlot >= NUM_SLOTS is ignored.
- ClearTimeout_H and a timeout on the same clock: set wins.
- DtackOut_L and BusError_L are never both 0.

Decomposition:
- Package dtack_ctrl_pkg holds:
  - state enum (IDLE, COUNT, WAIT_EXT, ASSERT, BERR, WAIT_AS_HIGH)
  - slot config struct {waits, ext_dtack}
  - timeout counter width constant, $clog2(TIMEOUT_CYCLES+1)
- One sub-module, dtack_slot_config_regs: the per-slot config register file with write port and combinational read by latched index.

Test Plan:
- No select, AS_L low at clock 0 -> DtackOut_L low at clock 1. AS_L high at clock 5 -> DtackOut_L high at clock 6.
- Slot 1, Waits=3 written, ExtDtack=0, Select_H=4'b0010, AS_L low at clock 0 -> DtackOut_L low at clock 4, not earlier.
- Slot 2, Waits=1, ExtDtack=1, DevDtack_L[2] low at clock 7 -> DtackOut_L low at clock 8.
- Slot 3, ExtDtack=1, DevDtack_L held high, TIMEOUT_CYCLES=255 -> BusError_L low at clock 255, DtackOut_L stays high, TimeoutSticky_H=1. After AS_L high, BusError_L=1. ClearTimeout_H -> sticky 0.
- Select_H=4'b0110, slot 1 Waits=0 and slot 2 Waits=5 -> slot 1 wins, Dtack at clock 1. Reprogram slot 1 to Waits=4 mid-cycle -> current cycle unaffected, next cycle Dtack at clock 5.
- Slot 0, Waits=10; AS_L high at clock 4 (abort) -> no Dtack, no BERR, IDLE. Reset_H pulsed during COUNT -> all outputs 1, waits back to 2.

Source files
------------

// File: rtl/dtack_ctrl_pkg.sv
// Shared types for the 68k Dtack wait-state controller:
// FSM state enum, per-slot config record, timeout width helper.
package dtack_ctrl_pkg;

  localparam int WAIT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    WAIT_EXT,
    ASSERT,
    BERR,
    WAIT_AS_HIGH
  } state_e;

  typedef struct packed {
    logic [WAIT_W-1:0] waits;
    logic              ext_dtack;
  } slot_cfg_t;

  // Watchdog counter width for a given timeout: $clog2(cycles+1).
  function automatic int timeout_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/dtack_slot_config_regs.sv
// Per-slot wait/ext-dtack table: one write port, one async read port.
// Ports: clk, rst_h, wr_en/wr_slot/wr_cfg, rd_slot -> rd_cfg.
module dtack_slot_config_regs
  import dtack_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS     = 4,
  parameter int IW            = 2,
  parameter int DEFAULT_WAITS = 2
) (
  input  logic          clk,
  input  logic          rst_h,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_slot,
  input  slot_cfg_t     wr_cfg,
  input  logic [IW-1:0] rd_slot,
  output slot_cfg_t     rd_cfg
);

  slot_cfg_t cfg_q [NUM_SLOTS];
  slot_cfg_t cfg_d [NUM_SLOTS];

  always_comb begin
    cfg_d = cfg_q;
    if (wr_en && (int'(wr_slot) < NUM_SLOTS)) begin
      cfg_d[wr_slot] = wr_cfg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_h) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cfg_q[i] <= '{waits: WAIT_W'(DEFAULT_WAITS),
                      ext_dtack: 1'b0};
      end
    end else begin
      cfg_q <= cfg_d;
    end
  end

  assign rd_cfg = (int'(rd_slot) < NUM_SLOTS)
                ? cfg_q[rd_slot] : '0;

endmodule

// File: rtl/dtack_wait_state_controller.sv
// Registered Dtack/BERR sequencer with per-slot wait states,
// optional device Dtack and a watchdog. Ports: Clock, Reset_H,
// AS_L, Select_H, DevDtack_L, Cfg* write port, ClearTimeout_H
// -> DtackOut_L, BusError_L, TimeoutSticky_H.
module dtack_wait_state_controller
  import dtack_ctrl_pkg::*;
#(
  parameter  int NUM_SLOTS      = 4,
  parameter  int WAIT_WIDTH     = 5,
  parameter  int DEFAULT_WAITS  = 2,
  parameter  int TIMEOUT_CYCLES = 255,
  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                  Clock,
  input  logic                  Reset_H,
  input  logic                  AS_L,
  input  logic [NUM_SLOTS-1:0]  Select_H,
  input  logic [NUM_SLOTS-1:0]  DevDtack_L,
  input  logic                  CfgWrite_H,
  input  logic [IW-1:0]         CfgSlot,
  input  logic [WAIT_WIDTH-1:0] CfgWaits,
  input  logic                  CfgExtDtack_H,
  input  logic                  ClearTimeout_H,
  output logic                  DtackOut_L,
  output logic                  BusError_L,
  output logic                  TimeoutSticky_H
);

  localparam int TW = timeout_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [WAIT_WIDTH-1:0] cnt_q, cnt_d;
  logic                  ext_q, ext_d;
  logic [TW-1:0]         wd_q, wd_d;
  logic                  as_high_q, as_high_d;
  logic                  dtack_q, dtack_d;
  logic                  berr_q, berr_d;
  logic                  sticky_q, sticky_d;
  logic                  timeout;
  logic [IW-1:0]         lowest;
  logic                  any_sel;
  logic [IW-1:0]         rd_idx;
  slot_cfg_t             rd_cfg;
  slot_cfg_t             wr_cfg;

  assign wr_cfg = '{waits: WAIT_W'(CfgWaits),
                    ext_dtack: CfgExtDtack_H};
  assign rd_idx = (state_q == IDLE) ? lowest : idx_q;

  dtack_slot_config_regs #(
    .NUM_SLOTS    (NUM_SLOTS),
    .IW           (IW),
    .DEFAULT_WAITS(DEFAULT_WAITS)
  ) u_cfg (
    .clk    (Clock),
    .rst_h  (Reset_H),
    .wr_en  (CfgWrite_H),
    .wr_slot(CfgSlot),
    .wr_cfg (wr_cfg),
    .rd_slot(rd_idx),
    .rd_cfg (rd_cfg)
  );

  // Lowest-index select wins.
  always_comb begin
    lowest  = '0;
    any_sel = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (Select_H[i]) begin
        lowest  = IW'(i);
        any_sel = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ext_d     = ext_q;
    wd_d      = wd_q;
    as_high_d = AS_L;
    timeout   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!AS_L) begin
          // A fresh cycle needs AS_L seen high first.
          if (!as_high_q) begin
            state_d = WAIT_AS_HIGH;
          end else if (!any_sel) begin
            state_d = ASSERT;
          end else begin
            idx_d = lowest;
            cnt_d = WAIT_WIDTH'(rd_cfg.waits);
            ext_d = rd_cfg.ext_dtack;
            wd_d  = TW'(1);
            if (rd_cfg.waits == '0) begin
              state_d = rd_cfg.ext_dtack ? WAIT_EXT : ASSERT;
            end else begin
              state_d = COUNT;
            end
          end
        end
      end
      COUNT: begin
        wd_d = wd_q + TW'(1);
        if (AS_L) begin
          state_d = IDLE;
        end else if (cnt_q == WAIT_WIDTH'(1) && !ext_q) begin
          state_d = ASSERT;
        end else if (wd_q == TO_LAST) begin
          timeout = 1'b1;
        end else if (cnt_q == WAIT_WIDTH'(1)) begin
          state_d = WAIT_EXT;
        end else begin
          cnt_d = cnt_q - WAIT_WIDTH'(1);
        end
      end
      WAIT_EXT: begin
        wd_d = wd_q + TW'(1);
        if (AS_L) begin
          state_d = IDLE;
        end else if (!DevDtack_L[idx_q]) begin
          state_d = ASSERT;
        end else if (wd_q == TO_LAST) begin
          timeout = 1'b1;
        end
      end
      ASSERT, BERR, WAIT_AS_HIGH: begin
        if (AS_L) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d = BERR;
    end
    // A timeout on the same clock as a clear keeps the flag set.
    sticky_d = timeout | (sticky_q & ~ClearTimeout_H);
    dtack_d  = (state_d != ASSERT);
    berr_d   = (state_d != BERR);
  end

  always_ff @(posedge Clock) begin
    if (Reset_H) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      ext_q     <= 1'b0;
      wd_q      <= '0;
      as_high_q <= 1'b0;
      dtack_q   <= 1'b1;
      berr_q    <= 1'b1;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ext_q     <= ext_d;
      wd_q      <= wd_d;
      as_high_q <= as_high_d;
      dtack_q   <= dtack_d;
      berr_q    <= berr_d;
      sticky_q  <= sticky_d;
    end
  end

  assign DtackOut_L      = dtack_q;
  assign BusError_L      = berr_q;
  assign TimeoutSticky_H = sticky_q;

endmodule
